rom_download_sequencer: RTL

// - Sits between the HPS ioctl download stream and the dual-port SDRAM controller, in the clk_mem domain.
// - Buffers incoming ROM bytes and issues toggle-handshake writes on SDRAM port1 (CPU/sound image).
// - Also issues writes on port2 (sprite image, remapped to 32-bit words), waiting for each ack.
// - Replaces the free-running req toggle; throttles the HPS via ioctl_wait and flags rom_ready when all writes land.

---
 rtl/rom_dl_pkg.sv | 23 ++
 rtl/rom_dl_fifo.sv | 58 +++++
 rtl/rom_download_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rom_dl_pkg.sv
// rtl/rom_dl_pkg.sv - shared state type, sprite region defaults and sprite address remap
package rom_dl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } dl_state_t;

  localparam logic [24:0] SP_BASE_DEFAULT = 25'h10000;
  localparam logic [24:0] SP_END_DEFAULT  = 25'h1BFFF;

  // Returns {ds[1:0], a[22:0]} for a sprite byte. off[15] selects the 16-bit half of a
  // 32-bit sprite word and off[14] selects the byte lane, so the four bytes of a sprite
  // word end up in two adjacent SDRAM words.
  function automatic logic [24:0] sprite_remap(input logic [24:0] addr,
                                               input logic [24:0] base);
    logic [23:0] off;
    off = 24'(addr - base);
    return {off[14], ~off[14], off[23:16], off[13:0], off[15]};
  endfunction

endpackage

// File: rtl/rom_dl_fifo.sv
// rtl/rom_dl_fifo.sv - synchronous FIFO buffering download entries
// clk, reset    : clock, synchronous active-high reset (flushes pointers and count)
// push, push_data : write strobe and data; ignored when full
// pop, pop_data   : read strobe and head data (head is valid whenever not empty)
// count, full, empty : occupancy status
module rom_dl_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_download_sequencer.sv
// rtl/rom_download_sequencer.sv - buffers ioctl ROM bytes and writes them to SDRAM port1/port2
// clk, reset        : memory clock, synchronous active-high reset
// ioctl_*           : HPS download stream in; ioctl_wait stalls the HPS
// port1_*, port2_*  : toggle-handshake SDRAM write ports (port2 carries the remapped sprite image)
// port_we           : write enable shared by both ports
// rom_ready         : all bytes of the ROM image have been written
module rom_download_sequencer
  import rom_dl_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  ROM_INDEX  = 8'd0,
  parameter logic [24:0] SP_BASE    = SP_BASE_DEFAULT,
  parameter logic [24:0] SP_END     = SP_END_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port_we,
  output logic        rom_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dl_state_t   state;
  dl_state_t   state_n;
  logic        pop;
  logic        issue;
  logic        wr_q;
  logic        dl_q;
  logic        push_req;
  logic        push;
  logic        dl_rise_rom;
  logic        overflow;
  logic        busy;
  logic        acks_done;
  logic        p2_issued;
  logic        cur_in_sp;
  logic [24:0] cur_addr;
  logic [7:0]  cur_data;
  logic [24:0] remap;
  logic [32:0] fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic        fifo_full;
  logic        fifo_empty;

  // One push per rising edge of the (possibly multi-cycle) byte strobe.
  assign push_req    = ioctl_wr & ~wr_q & ioctl_download & (ioctl_index == ROM_INDEX);
  assign push        = push_req & ~fifo_full;
  assign dl_rise_rom = ioctl_download & ~dl_q & (ioctl_index == ROM_INDEX);

  // A write is complete only when the ack has caught up with the current req value;
  // an ack changing in the toggle cycle is compared against the new req and so does not count.
  assign acks_done = (port1_ack == port1_req) && (!p2_issued || (port2_ack == port2_req));

  assign busy      = (state != IDLE) || !fifo_empty;
  assign port_we   = ioctl_download | busy;

  assign cur_in_sp = (cur_addr >= SP_BASE) && (cur_addr <= SP_END);
  assign remap     = sprite_remap(cur_addr, SP_BASE);

  rom_dl_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({ioctl_addr, ioctl_dout}),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    issue   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        issue   = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        if (acks_done) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_n = ISSUE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q       <= 1'b0;
      dl_q       <= 1'b0;
      ioctl_wait <= 1'b0;
      overflow   <= 1'b0;
      rom_ready  <= 1'b0;
      cur_addr   <= '0;
      cur_data   <= '0;
      p2_issued  <= 1'b0;
      port1_req  <= 1'b0;
      port1_a    <= '0;
      port1_ds   <= '0;
      port1_d    <= '0;
      port2_req  <= 1'b0;
      port2_a    <= '0;
      port2_ds   <= '0;
      port2_d    <= '0;
    end else begin
      wr_q <= ioctl_wr;
      dl_q <= ioctl_download;
      // Registered, so it lags the count by a clock; stalling one slot early absorbs that.
      ioctl_wait <= (fifo_count >= CW'(FIFO_DEPTH - 1));
      overflow   <= overflow | (push_req & fifo_full);

      if (dl_rise_rom) begin
        rom_ready <= 1'b0;
      end else if (!ioctl_download && !busy) begin
        rom_ready <= 1'b1;
      end

      if (pop) begin
        cur_addr <= fifo_rdata[32:8];
        cur_data <= fifo_rdata[7:0];
      end

      if (issue) begin
        port1_a   <= cur_addr[23:1];
        port1_ds  <= {cur_addr[0], ~cur_addr[0]};
        port1_d   <= {cur_data, cur_data};
        port1_req <= ~port1_req;
        p2_issued <= cur_in_sp;
        // Outside the sprite region port2 keeps its last address/data.
        if (cur_in_sp) begin
          port2_a   <= remap[22:0];
          port2_ds  <= remap[24:23];
          port2_d   <= {cur_data, cur_data};
          port2_req <= ~port2_req;
        end
      end
    end
  end

endmodule
